// File: rtl/seg7_hex_display.sv
// Loadable/incrementable DIGITS-nibble hex value driving active-low 7-segment digits.
// value and seg both update 1 cycle after load/inc; no backpressure, inputs act every edge.
module seg7_hex_display #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  inc,
  input  logic                  enable,
  input  logic                  lz_suppress,
  input  logic                  blink_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [4*DIGITS-1:0]   value,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int W  = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          run_zero;
  logic          blank;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] r;
    case (nib)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0011000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = value_in;
    end else if (inc) begin
      value_d = value_q + W'(1);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Decode from next-state value/phase so seg has no skew against value.
  always_comb begin
    seg_d    = '1;
    run_zero = 1'b1;
    blank    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero & (value_d[4*i +: 4] == 4'd0);
      blank    = !enable
                 || (lz_suppress && (i > 0) && run_zero)
                 || (phase_d && blink_mask[i]);
      seg_d[7*i +: 7] = blank ? 7'b1111111 : hex_decode(value_d[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= '1;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign value = value_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_seg7_hex_display.sv
// Bench for seg7_hex_display (DIGITS=8, BLINK_DIV=4): vector table, corner sequences, random run.
module tb_seg7_hex_display;

  localparam int BD = 4;
  localparam int BL = 16;  // digit code meaning "blank" in mk()

  localparam logic [6:0] CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, inc, enable, lz_suppress, blink_en;
  logic [31:0] value_in;
  logic [7:0]  blink_mask;
  logic [31:0] value;
  logic [55:0] seg;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_val;
  int          m_n;     // consecutive edges with blink_en sampled high
  logic [55:0] m_seg;

  seg7_hex_display #(.DIGITS(8), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .inc(inc),
    .enable(enable), .lz_suppress(lz_suppress), .blink_en(blink_en),
    .blink_mask(blink_mask), .value(value), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        in;
    logic [31:0] vin;
    logic        en;
    logic        lz;
    logic [31:0] ev;
    logic [55:0] es;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [55:0] mk(input int d7, d6, d5, d4, d3, d2, d1, d0);
    int d [8];
    logic [55:0] r;
    d = '{d0, d1, d2, d3, d4, d5, d6, d7};
    for (int i = 0; i < 8; i++) r[7*i +: 7] = (d[i] == BL) ? 7'h7F : CODES[d[i]];
    return r;
  endfunction

  function automatic logic [55:0] expect_seg(input logic [31:0] v, input logic en,
                                             input logic lz, input logic ph,
                                             input logic [7:0] mask);
    logic [55:0] r;
    logic        b;
    for (int i = 0; i < 8; i++) begin
      b = !en || (lz && i > 0 && (v >> (4*i)) == 0) || (ph && mask[i]);
      r[7*i +: 7] = b ? 7'h7F : CODES[v[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0;
    m_n   = 0;
    m_seg = '1;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    logic ph;
    if (load) m_val = value_in;
    else if (inc) m_val = m_val + 1;
    m_n = blink_en ? m_n + 1 : 0;
    ph  = ((m_n / BD) % 2) == 1;
    m_seg = expect_seg(m_val, enable, lz_suppress, ph, blink_mask);
  endtask

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp56(input string nm, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input string nm);
    model_step();
    @(posedge clk);
    #1;
    cmp32({nm, "_value"}, value, m_val);
    cmp56({nm, "_seg"}, seg, m_seg);
  endtask

  initial begin
    rst_n = 1'b0; load = 0; inc = 0; value_in = 0; enable = 1; lz_suppress = 0;
    blink_en = 0; blink_mask = 0;
    model_reset();

    tbl[0]  = '{1, 0, 32'h76543210, 1, 0, 32'h76543210, mk(7,6,5,4,3,2,1,0)};
    tbl[1]  = '{1, 0, 32'hFEDCBA98, 1, 0, 32'hFEDCBA98, mk(15,14,13,12,11,10,9,8)};
    tbl[2]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, mk(15,15,15,15,15,15,15,15)};
    tbl[3]  = '{0, 1, 32'h0,        1, 0, 32'h00000000, mk(0,0,0,0,0,0,0,0)};
    tbl[4]  = '{1, 1, 32'h00000010, 1, 0, 32'h00000010, mk(0,0,0,0,0,0,1,0)};
    tbl[5]  = '{0, 1, 32'h0,        1, 0, 32'h00000011, mk(0,0,0,0,0,0,1,1)};
    tbl[6]  = '{1, 0, 32'h00000A05, 1, 1, 32'h00000A05, mk(BL,BL,BL,BL,BL,10,0,5)};
    tbl[7]  = '{1, 0, 32'h00000000, 1, 1, 32'h00000000, mk(BL,BL,BL,BL,BL,BL,BL,0)};
    tbl[8]  = '{1, 0, 32'h80000000, 1, 1, 32'h80000000, mk(8,0,0,0,0,0,0,0)};
    tbl[9]  = '{0, 1, 32'h0,        0, 1, 32'h80000001, mk(BL,BL,BL,BL,BL,BL,BL,BL)};
    tbl[10] = '{1, 0, 32'h00000001, 1, 0, 32'h00000001, mk(0,0,0,0,0,0,0,1)};
    tbl[11] = '{0, 0, 32'h0,        1, 1, 32'h00000001, mk(BL,BL,BL,BL,BL,BL,BL,1)};

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #2;
    cmp32("reset_value", value, 32'h0);
    cmp56("reset_seg", seg, {56{1'b1}});
    @(negedge clk);
    rst_n = 1'b1;
    tick("release");
    cmp56("release_all_zero", seg, {8{7'b1000000}});

    foreach (tbl[k]) begin
      load = tbl[k].ld; inc = tbl[k].in; value_in = tbl[k].vin;
      enable = tbl[k].en; lz_suppress = tbl[k].lz;
      model_step();
      @(posedge clk);
      #1;
      cmp32($sformatf("vec%0d_value", k), value, tbl[k].ev);
      cmp56($sformatf("vec%0d_seg", k), seg, tbl[k].es);
    end

    // Blink: mask 0F, 4 blank / 4 visible
    load = 1; inc = 0; value_in = 32'h12345678; lz_suppress = 0; enable = 1;
    tick("blink_load");
    load = 0; blink_en = 1; blink_mask = 8'h0F;
    for (int c = 1; c <= 13; c++) begin
      tick($sformatf("blink_c%0d", c));
      if (c == 4) cmp56("blink_first_blank", seg, {7'h79, 7'h24, 7'h30, 7'h19, {4{7'h7F}}});
      if (c == 8) cmp56("blink_visible", seg, mk(1,2,3,4,5,6,7,8));
    end
    blink_en = 0;
    tick("blink_drop");
    cmp56("blink_drop_visible", seg, mk(1,2,3,4,5,6,7,8));

    // Async reset between edges during inc
    inc = 1;
    tick("pre_arst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp32("arst_value", value, 32'h0);
    cmp56("arst_seg", seg, {56{1'b1}});
    @(negedge clk);
    rst_n = 1'b1;
    inc = 0;
    tick("post_arst");

    // Randomized run against the model
    for (int c = 0; c < 400; c++) begin
      load        = ($urandom_range(3, 0) == 0);
      inc         = ($urandom_range(1, 0) == 1);
      value_in    = ($urandom_range(2, 0) == 0) ? (32'hFFFFFFF0 | $urandom_range(15, 0)) : $urandom;
      enable      = ($urandom_range(7, 0) != 0);
      lz_suppress = $urandom_range(1, 0);
      blink_en    = ($urandom_range(15, 0) != 0);
      blink_mask  = $urandom_range(255, 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_hex_display.md
# seg7_hex_display

Registered, parametrised multi-digit hex display driver for the NVBoard seven-segment bank. It holds a DIGITS-nibble value that can be loaded or incremented. Each nibble drives one active-low digit, with global blanking, leading-zero suppression and per-digit blinking. All segment outputs are registered. The block sits between application logic (counters, keyboard/ALU result registers) and the board's seg pins.

## Interface

Parameters:
- DIGITS, 8, number of digits; legal 1..8.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  on a clk edge, latch value_in into the value register.
- value_in  in  4*DIGITS  new value; nibble i feeds digit i, and digit 0 is the least significant.
- inc  in  1  on a clk edge, increment the value register by 1 modulo 2^(4*DIGITS).
- enable  in  1  0 blanks every digit.
- lz_suppress  in  1  1 blanks leading zero digits.
- blink_en  in  1  1 enables blinking.
- blink_mask  in  DIGITS  digits that blink when blink_en=1.
- value  out  4*DIGITS  current value register.
- seg  out  7*DIGITS  segments, active-low; seg[7i+k] is segment k of digit i, with k=0..6 mapping to a..g.

## Operation

- Value register, next-state priority:
  - rst_n=0 → 0.
  - load=1 → value_in. load wins when load and inc are both high; the increment is dropped.
  - inc=1 → value+1. All-F wraps to 0.
  - Otherwise hold.
- Blink timer, a counter with a phase bit:
  - blink_en=0 → counter=0, phase=0.
  - blink_en=1 → counter increments each cycle. At BLINK_DIV-1 it wraps to 0 and phase toggles.
  - Deasserting blink_en mid-period clears counter and phase on the next edge.
- Digit i is blank when any of the following holds:
  - enable=0.
  - lz_suppress=1, i>0, and every nibble j≥i is 0. Digit 0 is never suppressed, so value 0 displays "0".
  - blink_en=1, phase=1, and blink_mask[i]=1.
- A blank digit outputs 7'b1111111. Otherwise the digit is decoded from nibble i as seg[7i+6:7i], in g..a order:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0011000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- seg is a register. Its next value is the decode of the next value register, the next phase, and the current enable, lz_suppress and blink_mask.

## Timing

- Reset values: value=0, counter=0, phase=0, seg all ones (every digit blank).
- Because seg is registered, the first edge after rst_n rises shows "0" on digit 0, or all digits at 0 if lz_suppress=0, provided enable=1.
- load/inc to outputs: value and seg both reflect the change one edge after the load/inc edge. Latency is 1 cycle and there is no skew between value and seg.
- enable, lz_suppress and blink_mask take effect on seg 1 cycle after the edge where they are sampled.
- Blink period is 2*BLINK_DIV cycles, with a 50% duty cycle. The first blank phase starts BLINK_DIV cycles after blink_en is first sampled high.
- Asserting rst_n=0 mid-operation (including mid-blink or during inc) forces all reset values immediately, with no clock required.
- inc held high counts once per cycle with no throttling.

## Test plan

All scenarios use DIGITS=8 and BLINK_DIV=4.

- Reset: rst_n=0 with clk running → seg=all 1s and value=0 asynchronously. Release with enable=1, lz_suppress=0 → one edge later seg[6:0]=1000000 on all 8 digits.
- Decode sweep: load value_in=32'h76543210, then 32'hFEDCBA98 → one edge after each load, seg digits match the 16 encodings above.
- Increment, wrap and priority:
  - load 32'hFFFFFFFF, then inc → value=0.
  - load=1 and inc=1 with value_in=32'h00000010 → value=32'h00000010, not 11.
- Leading-zero suppression: lz_suppress=1, value 32'h00000A05 → digits 7..3 blank, digits 2..0 show A, 0, 5. Value 0 → only digit 0 shows 1000000.
- Blink:
  - blink_en=1, blink_mask=8'h0F → digits 3..0 blank for 4 cycles, then visible for 4 cycles, repeating. Digits 7..4 never blank.
  - Dropping blink_en while blanked → all digits visible on seg one cycle after the next edge.
- Enable and async reset:
  - enable=0 → all seg=1s one cycle later, while value still increments on inc.
  - rst_n pulsed low between edges → value=0 without a clk edge.
